// File: rtl/tile_pkg.sv
// tile_pkg: shared constants and types for the tile map and its writers.
//   TILE_SIZE / GRID_DIM / FIELD_PIX : tile geometry of the 640x640 playfield
//   tile_type_t                       : 2-bit tile type stored in the map
//   tws_state_t                       : tile_write_scheduler FSM states
//   pix_to_tile()                     : pixel coordinate -> tile index; the
//                                       renderer calls it too, so both sides
//                                       divide identically
package tile_pkg;

  localparam int TILE_SIZE = 80;
  localparam int GRID_DIM  = 8;
  localparam int FIELD_PIX = TILE_SIZE * GRID_DIM;

  typedef enum logic [1:0] {
    TILE_EMPTY  = 2'd0,
    TILE_WALL   = 2'd1,
    TILE_ITEM   = 2'd2,
    TILE_HAZARD = 2'd3
  } tile_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } tws_state_t;

  // Divide on the full 11-bit operand, keep the low 3 bits of the quotient.
  function automatic logic [2:0] pix_to_tile(input logic [10:0] pix,
                                             input logic [10:0] tile_size);
    return 3'(pix / tile_size);
  endfunction

endpackage

// File: rtl/tile_write_scheduler_if.sv
// tile_write_scheduler_if: request, clear-control and tile-map write bus.
//   frame_blank          : writes permitted this cycle
//   req_valid/x/y/type   : per-requester request (packed, requester i in slot i)
//   req_ready            : one-hot combinational acceptance strobe
//   clear_start/type     : full-map clear command and fill type
//   busy                 : clear sweep in progress
//   writeEn/col/row/type : registered tile-map write
//   drop_err             : accepted request was off the playfield
// master = requesters/host side, slave = scheduler.
interface tile_write_scheduler_if #(
  parameter int NUM_REQ = 3
);
  logic                       frame_blank;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0][10:0]   req_x;
  logic [NUM_REQ-1:0][10:0]   req_y;
  logic [NUM_REQ-1:0][1:0]    req_type;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       clear_start;
  logic [1:0]                 clear_type;
  logic                       busy;
  logic                       writeEn;
  logic [2:0]                 write_col;
  logic [2:0]                 write_row;
  logic [1:0]                 write_type;
  logic                       drop_err;

  modport master (
    output frame_blank, req_valid, req_x, req_y, req_type, clear_start, clear_type,
    input  req_ready, busy, writeEn, write_col, write_row, write_type, drop_err
  );

  modport slave (
    input  frame_blank, req_valid, req_x, req_y, req_type, clear_start, clear_type,
    output req_ready, busy, writeEn, write_col, write_row, write_type, drop_err
  );
endinterface

// File: rtl/tile_write_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req_i   : request vector
//   last_i  : index of the previous winner; search starts at last_i+1
//   grant_o : one-hot grant (zero when no request)
//   idx_o   : index of the winner (last_i when no request)
//   any_o   : at least one request present
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int LW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [LW-1:0]      last_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [LW-1:0]      idx_o,
  output logic               any_o
);

  logic [LW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = last_i;
    any_o   = 1'b0;
    cand    = '0;
    // off=NUM_REQ wraps back to last_i itself, so a lone requester that
    // just won can win again.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = LW'((int'(last_i) + off) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_write_scheduler.sv
// tile_write_scheduler: arbitrates pixel-coordinate tile writes from NUM_REQ
// requesters into the 8x8 tile map, one registered write per cycle and only
// during blanking; a clear command sweeps all 64 tiles and pre-empts requests.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : tile_write_scheduler_if slave (requests, clear control, write port)
module tile_write_scheduler #(
  parameter int NUM_REQ   = 3,
  parameter int TILE_SIZE = tile_pkg::TILE_SIZE,
  parameter int GRID_DIM  = tile_pkg::GRID_DIM
) (
  input  logic                  clk,
  input  logic                  reset,
  tile_write_scheduler_if.slave bus
);
  import tile_pkg::*;

  localparam int          LW        = $clog2(NUM_REQ);
  localparam logic [11:0] FIELD_LIM = 12'(GRID_DIM * TILE_SIZE);
  localparam logic [10:0] TS        = 11'(TILE_SIZE);

  tws_state_t         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [LW-1:0]      last_q, last_d;
  logic               we_q, we_d;
  logic               drop_q, drop_d;
  logic [2:0]         col_q, col_d;
  logic [2:0]         row_q, row_d;
  logic [1:0]         typ_q, typ_d;

  logic [NUM_REQ-1:0] grant;
  logic [LW-1:0]      gidx;
  logic               gany;
  logic               arb_en;
  logic [10:0]        gx, gy;
  logic [1:0]         gt;
  logic               oor;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (bus.req_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  assign gx  = bus.req_x[gidx];
  assign gy  = bus.req_y[gidx];
  assign gt  = bus.req_type[gidx];
  assign oor = ({1'b0, gx} >= FIELD_LIM) || ({1'b0, gy} >= FIELD_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    we_d    = 1'b0;
    drop_d  = 1'b0;
    col_d   = col_q;
    row_d   = row_q;
    typ_d   = typ_q;
    arb_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (bus.frame_blank && gany) begin
          arb_en = 1'b1;
          last_d = gidx;
          // Off-field requests are still acknowledged so the requester
          // moves on; only the write is suppressed.
          if (oor) begin
            drop_d = 1'b1;
          end else begin
            we_d  = 1'b1;
            col_d = pix_to_tile(gx, TS);
            row_d = pix_to_tile(gy, TS);
            typ_d = gt;
          end
        end
      end
      ST_CLEAR: begin
        if (bus.frame_blank) begin
          we_d  = 1'b1;
          col_d = cnt_q[2:0];
          row_d = cnt_q[5:3];
          typ_d = bus.clear_type;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LW'(NUM_REQ - 1);
      we_q    <= 1'b0;
      drop_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      typ_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      drop_q  <= drop_d;
      col_q   <= col_d;
      row_q   <= row_d;
      typ_q   <= typ_d;
    end
  end

  assign bus.req_ready  = arb_en ? grant : '0;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.writeEn    = we_q;
  assign bus.drop_err   = drop_q;
  assign bus.write_col  = col_q;
  assign bus.write_row  = row_q;
  assign bus.write_type = typ_q;

endmodule

// File: tb/tb_tile_write_scheduler.sv
// Directed bench for tile_write_scheduler with a write scoreboard.
module tb_tile_write_scheduler;
  import tile_pkg::*;

  localparam int NR = 3;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tile_write_scheduler_if #(.NUM_REQ(NR)) bus();

  tile_write_scheduler #(
    .NUM_REQ   (NR),
    .TILE_SIZE (TILE_SIZE),
    .GRID_DIM  (GRID_DIM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       drop;
    logic [2:0] col;
    logic [2:0] row;
    logic [1:0] typ;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   tcnt  = 0;
  bit   toggle = 1'b0;
  logic blank_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [10:0] x, input logic [10:0] y, input logic [1:0] t);
    exp_t e;
    e.drop = (x >= 11'd640) || (y >= 11'd640);
    e.col  = 3'(x / 11'd80);
    e.row  = 3'(y / 11'd80);
    e.typ  = t;
    return e;
  endfunction

  // Advance to just after the next active edge; optionally toggle blank
  // every 4 cycles.
  task automatic cyc();
    @(posedge clk);
    #1;
    tcnt++;
    if (toggle) bus.frame_blank = ((tcnt / 4) % 2) == 0;
  endtask

  // Called at a negedge: returns the granted index, advancing up to budget cycles.
  task automatic wait_ready(input string tag, input int budget, output int idx);
    idx = -1;
    for (int n = 0; n <= budget; n++) begin
      if (|bus.req_ready) begin
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) idx = i;
        check({tag, "_onehot"}, 32'($onehot(bus.req_ready)), 32'd1);
        return;
      end
      if (n == budget) begin
        check({tag, "_timeout"}, 32'd0, 32'd1);
        return;
      end
      cyc();
      @(negedge clk);
    end
  endtask

  task automatic accept(input int idx);
    logic [1:0] k;
    k = 2'(idx);
    sb.push_back(model(bus.req_x[k], bus.req_y[k], bus.req_type[k]));
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_we"},    32'(bus.writeEn),    32'd0);
    check({tag, "_col"},   32'(bus.write_col),  32'd0);
    check({tag, "_row"},   32'(bus.write_row),  32'd0);
    check({tag, "_type"},  32'(bus.write_type), 32'd0);
    check({tag, "_drop"},  32'(bus.drop_err),   32'd0);
    check({tag, "_busy"},  32'(bus.busy),       32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready),  32'd0);
  endtask

  // Write monitor: every write/drop must match the oldest scoreboard entry
  // and follow a blank cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        blank_prev = 1'b0;
      end else begin
        if (bus.writeEn || bus.drop_err) begin
          check("we_drop_excl", 32'(bus.writeEn & bus.drop_err), 32'd0);
          check("wr_after_blank", 32'(blank_prev), 32'd1);
          if (sb.size() == 0) begin
            check("unexpected_wr", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("sb_drop", 32'(bus.drop_err), 32'(e.drop));
            check("sb_we",   32'(bus.writeEn),  32'(!e.drop));
            if (!e.drop) begin
              check("sb_colrowtype",
                    32'({bus.write_col, bus.write_row, bus.write_type}),
                    32'({e.col, e.row, e.typ}));
            end
          end
        end
        blank_prev = bus.frame_blank;
      end
    end
  end

  task automatic set_req(input int i, input logic [10:0] x, input logic [10:0] y, input logic [1:0] t);
    logic [1:0] k;
    k = 2'(i);
    bus.req_x[k]    = x;
    bus.req_y[k]    = y;
    bus.req_type[k] = t;
  endtask

  initial begin
    int g;
    int n;
    bus.frame_blank = 1'b0;
    bus.req_valid   = '0;
    bus.req_x       = '0;
    bus.req_y       = '0;
    bus.req_type    = '0;
    bus.clear_start = 1'b0;
    bus.clear_type  = 2'd0;
    reset = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk_reset("por");
    cyc();
    reset = 1'b0;

    // Round robin with all three requesters continuously valid.
    set_req(0, 11'd10,  11'd20,  2'd1);
    set_req(1, 11'd250, 11'd330, 2'd2);
    set_req(2, 11'd560, 11'd630, 2'd3);
    bus.req_valid   = 3'b111;
    bus.frame_blank = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_ready("rr", 2, g);
      check("rr_order", 32'(g), 32'(k % 3));
      if (k > 0) check("rr_b2b_we", 32'(bus.writeEn), 32'd1);
      accept(g);
      cyc();
      @(negedge clk);
    end
    bus.req_valid = '0;

    // Single request: 1-cycle grant-to-write latency, explicit decode.
    cyc();
    set_req(0, 11'd165, 11'd85, 2'd2);
    bus.req_valid = 3'b001;
    @(negedge clk);
    wait_ready("single", 2, g);
    check("single_ready", 32'(bus.req_ready), 32'b001);
    accept(g);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    check("single_we",   32'(bus.writeEn),    32'd1);
    check("single_col",  32'(bus.write_col),  32'd2);
    check("single_row",  32'(bus.write_row),  32'd1);
    check("single_type", 32'(bus.write_type), 32'd2);

    // Pending request held off by active display.
    cyc();
    bus.frame_blank = 1'b0;
    set_req(2, 11'd300, 11'd500, 2'd3);
    bus.req_valid = 3'b100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("noblank_ready", 32'(bus.req_ready), 32'd0);
      check("noblank_we",    32'(bus.writeEn),   32'd0);
      cyc();
    end
    bus.frame_blank = 1'b1;
    @(negedge clk);
    wait_ready("blank_rise", 0, g);
    check("blank_rise_idx", 32'(g), 32'd2);
    accept(g);
    cyc();
    bus.req_valid = '0;

    // Out-of-range drop, then the far corner of the field.
    set_req(1, 11'd700, 11'd10, 2'd0);
    bus.req_valid = 3'b010;
    @(negedge clk);
    wait_ready("oor", 2, g);
    check("oor_idx", 32'(g), 32'd1);
    accept(g);
    cyc();
    set_req(1, 11'd639, 11'd639, 2'd1);
    @(negedge clk);
    check("oor_drop", 32'(bus.drop_err), 32'd1);
    check("oor_we",   32'(bus.writeEn),  32'd0);
    wait_ready("corner", 0, g);
    accept(g);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    check("drop_pulse", 32'(bus.drop_err),  32'd0);
    check("corner_we",  32'(bus.writeEn),   32'd1);
    check("corner_col", 32'(bus.write_col), 32'd7);
    check("corner_row", 32'(bus.write_row), 32'd7);

    // Clear sweep with blank toggling every 4 cycles.
    cyc();
    tcnt = 0;
    bus.frame_blank = 1'b1;
    bus.clear_type  = 2'd1;
    bus.clear_start = 1'b1;
    for (int i = 0; i < 64; i++) sb.push_back('{1'b0, 3'(i), 3'(i >> 3), 2'd1});
    @(negedge clk);
    check("clr_busy_n", 32'(bus.busy), 32'd0);
    toggle = 1'b1;
    cyc();
    bus.clear_start = 1'b0;
    @(negedge clk);
    check("clr_busy_rise", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.busy && n < 400) begin
      check("clr_noready", 32'(bus.req_ready), 32'd0);
      cyc();
      n++;
      if (n == 12) begin
        bus.clear_start = 1'b1;
        set_req(0, 11'd85, 11'd165, 2'd3);
        bus.req_valid = 3'b001;
      end
      if (n == 13) bus.clear_start = 1'b0;
      @(negedge clk);
    end
    check("clr_end_timeout", 32'(n < 400), 32'd1);
    wait_ready("after_clr", 20, g);
    check("after_clr_busy", 32'(bus.busy), 32'd0);
    check("after_clr_idx",  32'(g), 32'd0);
    accept(g);
    cyc();
    bus.req_valid = '0;
    toggle = 1'b0;
    bus.frame_blank = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-sweep: outputs clear at once, sweep abandoned, req 0 first.
    cyc();
    bus.clear_type  = 2'd2;
    bus.clear_start = 1'b1;
    for (int i = 0; i < 64; i++) sb.push_back('{1'b0, 3'(i), 3'(i >> 3), 2'd2});
    cyc();
    bus.clear_start = 1'b0;
    repeat (8) cyc();
    reset = 1'b1;
    sb.delete();
    #1;
    chk_reset("async");
    repeat (2) cyc();
    reset = 1'b0;
    set_req(0, 11'd10,  11'd20,  2'd1);
    set_req(1, 11'd250, 11'd330, 2'd2);
    set_req(2, 11'd560, 11'd630, 2'd3);
    bus.req_valid = 3'b111;
    @(negedge clk);
    check("abandoned_busy", 32'(bus.busy), 32'd0);
    wait_ready("post_rst", 0, g);
    check("post_rst_first", 32'(g), 32'd0);
    accept(g);
    cyc();
    bus.req_valid = '0;
    cyc();
    cyc();
    @(negedge clk);
    check("sb_final", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
